ram_led_blinker: RTL and testbench

// Downstream consumer of the PCIe-to-RAM system's on-chip RAM local port (pcie_ram_bus).

---
 rtl/ram_led_blinker_if.sv | 22 ++
 rtl/ram_led_blinker.sv | 147 ++++++++++++++
 tb/tb_ram_led_blinker.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_led_blinker_if.sv
// rtl/ram_led_blinker_if.sv - RAM local-port bus between the blinker and the on-chip RAM
interface ram_led_blinker_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_chipselect;
    logic                  ram_clken;
    logic                  ram_write;
    logic [63:0]           ram_writedata;
    logic [7:0]            ram_byteenable;
    logic [63:0]           ram_readdata;

    modport master (
        output ram_address, ram_chipselect, ram_clken, ram_write, ram_writedata, ram_byteenable,
        input  ram_readdata
    );

    modport slave (
        input  ram_address, ram_chipselect, ram_clken, ram_write, ram_writedata, ram_byteenable,
        output ram_readdata
    );
endinterface

// File: rtl/ram_led_blinker.sv
// rtl/ram_led_blinker.sv - polls a config word from RAM, blinks LEDs from it, writes status back
module ram_led_blinker #(
    parameter int                    ADDR_WIDTH   = 12,
    parameter logic [ADDR_WIDTH-1:0] CFG_ADDR     = '0,
    parameter int                    POLL_CYCLES  = 1024,
    parameter int                    READ_LATENCY = 1,
    parameter int                    NUM_LEDS     = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    ram_led_blinker_if.master   ram,
    output logic [NUM_LEDS-1:0] led,
    output logic                blink_active
);
    localparam int                    PW          = $clog2(POLL_CYCLES);
    localparam logic [PW-1:0]         POLL_LAST   = PW'(POLL_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = CFG_ADDR + ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        POLL_WAIT,
        RD_ISSUE,
        RD_WAIT,
        CAPTURE,
        WR_STATUS
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_poll;
    logic                r_en;
    logic [31:0]         r_half;
    logic [7:0]          r_on;
    logic [7:0]          r_off;
    logic                r_phase;
    logic [31:0]         r_pcnt;
    logic [31:0]         r_toggles;
    logic [NUM_LEDS-1:0] r_led;

    logic                w_cap;
    logic                w_en;
    logic [31:0]         w_half;
    logic [7:0]          w_on;
    logic [7:0]          w_off;
    logic                w_phase_nxt;
    logic [31:0]         w_pcnt_nxt;
    logic [31:0]         w_tog_nxt;
    logic [NUM_LEDS-1:0] w_led_nxt;
    logic [63:0]         w_status;

    // During CAPTURE the engine already runs on the incoming word so the LEDs change one clock later.
    assign w_cap  = (r_state == CAPTURE);
    assign w_en   = w_cap ? ram.ram_readdata[63]    : r_en;
    assign w_half = w_cap ? ram.ram_readdata[47:16] : r_half;
    assign w_on   = w_cap ? ram.ram_readdata[7:0]   : r_on;
    assign w_off  = w_cap ? ram.ram_readdata[15:8]  : r_off;

    always_comb begin
        w_phase_nxt = r_phase;
        w_pcnt_nxt  = r_pcnt;
        w_tog_nxt   = r_toggles;
        // A fresh enable parks the counter so the first ON phase lasts a full half period.
        if (!w_en || (w_half == 32'd0) || !r_en) begin
            w_phase_nxt = 1'b1;
            w_pcnt_nxt  = 32'd0;
        end else if (r_pcnt >= (w_half - 32'd1)) begin
            w_phase_nxt = ~r_phase;
            w_pcnt_nxt  = 32'd0;
            w_tog_nxt   = r_toggles + 32'd1;
        end else begin
            w_pcnt_nxt  = r_pcnt + 32'd1;
        end
        w_led_nxt = '0;
        if (w_en) begin
            w_led_nxt = w_phase_nxt ? w_on[NUM_LEDS-1:0] : w_off[NUM_LEDS-1:0];
        end
    end

    // Phase bit reads 0 while disabled so an idle blinker reports a bare alive word.
    assign w_status = {1'b1, 22'b0, w_phase_nxt & w_en, 8'(w_led_nxt), w_tog_nxt};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_phase   <= 1'b1;
            r_pcnt    <= '0;
            r_toggles <= '0;
            r_led     <= '0;
        end else begin
            r_phase   <= w_phase_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_toggles <= w_tog_nxt;
            r_led     <= w_led_nxt;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state            <= POLL_WAIT;
            r_poll             <= '0;
            r_en               <= 1'b0;
            r_half             <= '0;
            r_on               <= '0;
            r_off              <= '0;
            ram.ram_address    <= '0;
            ram.ram_chipselect <= 1'b0;
            ram.ram_clken      <= 1'b0;
            ram.ram_write      <= 1'b0;
            ram.ram_writedata  <= '0;
            ram.ram_byteenable <= '0;
        end else begin
            r_poll             <= r_poll + PW'(1);
            ram.ram_chipselect <= 1'b0;
            ram.ram_clken      <= 1'b0;
            ram.ram_write      <= 1'b0;
            case (r_state)
                POLL_WAIT: begin
                    if (r_poll == POLL_LAST) begin
                        r_poll             <= '0;
                        r_state            <= RD_ISSUE;
                        ram.ram_address    <= CFG_ADDR;
                        ram.ram_chipselect <= 1'b1;
                        ram.ram_clken      <= 1'b1;
                        ram.ram_byteenable <= 8'hFF;
                    end
                end
                RD_ISSUE: r_state <= (READ_LATENCY > 1) ? RD_WAIT : CAPTURE;
                RD_WAIT:  r_state <= CAPTURE;
                CAPTURE: begin
                    r_en               <= ram.ram_readdata[63];
                    r_half             <= ram.ram_readdata[47:16];
                    r_on               <= ram.ram_readdata[7:0];
                    r_off              <= ram.ram_readdata[15:8];
                    r_state            <= WR_STATUS;
                    ram.ram_address    <= STATUS_ADDR;
                    ram.ram_chipselect <= 1'b1;
                    ram.ram_clken      <= 1'b1;
                    ram.ram_write      <= 1'b1;
                    ram.ram_writedata  <= w_status;
                    ram.ram_byteenable <= 8'hFF;
                end
                WR_STATUS: r_state <= POLL_WAIT;
                default:   r_state <= POLL_WAIT;
            endcase
        end
    end

    assign led          = r_led;
    assign blink_active = r_en;
endmodule

// File: tb/tb_ram_led_blinker.sv
// tb/tb_ram_led_blinker.sv - randomized self-checking bench for ram_led_blinker
`timescale 1ns/1ps
module tb_ram_led_blinker;
    localparam int P    = 32;
    localparam int HIST = 8192;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [11:0] addr;
        logic [63:0] data;
    } acc_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int r0    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ram_led_blinker_if #(.ADDR_WIDTH(12)) bus_a ();
    ram_led_blinker_if #(.ADDR_WIDTH(12)) bus_b ();
    logic [3:0] led_a;
    logic [3:0] led_b;
    logic       act_a;
    logic       act_b;

    ram_led_blinker #(.ADDR_WIDTH(12), .CFG_ADDR(12'h000), .POLL_CYCLES(P),
                      .READ_LATENCY(1), .NUM_LEDS(4)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .ram(bus_a), .led(led_a), .blink_active(act_a));

    ram_led_blinker #(.ADDR_WIDTH(12), .CFG_ADDR(12'h000), .POLL_CYCLES(P),
                      .READ_LATENCY(2), .NUM_LEDS(4)) dut_lat2 (
        .clk_clk(clk), .reset_reset_n(rst_n), .ram(bus_b), .led(led_b), .blink_active(act_b));

    // RAM models: read data is valid only in the cycle READ_LATENCY after issue, junk otherwise
    acc_t        q_a[$];
    acc_t        q_b[$];
    logic [63:0] cfg_a = '0;
    logic [63:0] cfg_b = '0;
    int          iss_a = -10;
    int          iss_b = -10;
    int          perr_a = 0;
    int          perr_b = 0;
    logic        pcs_a = 1'b0;
    logic        pcs_b = 1'b0;
    logic [3:0]  hist_a [HIST];
    logic [3:0]  hist_b [HIST];

    always @(negedge clk) begin
        bus_a.ram_readdata = (cyc == iss_a + 1) ? cfg_a : {$urandom, $urandom};
        if (bus_a.ram_chipselect === 1'b1) begin
            q_a.push_back('{cyc, bus_a.ram_write, bus_a.ram_address, bus_a.ram_writedata});
            if (bus_a.ram_write === 1'b0) iss_a = cyc;
        end
        if (bus_a.ram_clken !== bus_a.ram_chipselect) perr_a++;
        if (bus_a.ram_write === 1'b1 && bus_a.ram_chipselect !== 1'b1) perr_a++;
        if (bus_a.ram_chipselect === 1'b1 && bus_a.ram_byteenable !== 8'hFF) perr_a++;
        if (bus_a.ram_chipselect === 1'b1 && pcs_a) perr_a++;
        pcs_a = (bus_a.ram_chipselect === 1'b1);
        hist_a[cyc % HIST] = led_a;
    end

    always @(negedge clk) begin
        bus_b.ram_readdata = (cyc == iss_b + 2) ? cfg_b : {$urandom, $urandom};
        if (bus_b.ram_chipselect === 1'b1) begin
            q_b.push_back('{cyc, bus_b.ram_write, bus_b.ram_address, bus_b.ram_writedata});
            if (bus_b.ram_write === 1'b0) iss_b = cyc;
        end
        if (bus_b.ram_clken !== bus_b.ram_chipselect) perr_b++;
        if (bus_b.ram_write === 1'b1 && bus_b.ram_chipselect !== 1'b1) perr_b++;
        if (bus_b.ram_chipselect === 1'b1 && bus_b.ram_byteenable !== 8'hFF) perr_b++;
        if (bus_b.ram_chipselect === 1'b1 && pcs_b) perr_b++;
        pcs_b = (bus_b.ram_chipselect === 1'b1);
        hist_b[cyc % HIST] = led_b;
    end

    // Blink reference: from t0 the LEDs hold each pattern for n clocks, starting with ON
    function automatic logic [3:0] exp_led(input int t, input int t0, input int n,
                                           input logic [7:0] on, input logic [7:0] off);
        return ((((t - t0) / n) % 2) == 0) ? on[3:0] : off[3:0];
    endfunction

    function automatic int find_acc(input acc_t q[$], input int t);
        foreach (q[i]) if (q[i].cyc == t) return i;
        return -1;
    endfunction

    task automatic goto(input int t);
        do @(negedge clk); while (cyc < t);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        q_a.delete();
        q_b.delete();
        rst_n = 1'b1;
        r0 = cyc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();
    endtask

    task automatic test_reset();
        int idx;
        cfg_a = '0;
        cfg_b = '0;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({led_a, act_a, bus_a.ram_chipselect, bus_a.ram_clken, bus_a.ram_write} !== 8'h00 ||
            bus_a.ram_address !== 12'h000 || bus_a.ram_writedata !== 64'h0 || bus_a.ram_byteenable !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: led=%h act=%b cs=%b addr=%h wd=%h, want all 0",
                     led_a, act_a, bus_a.ram_chipselect, bus_a.ram_address, bus_a.ram_writedata);
        end
        release_reset();
        goto(r0 + P + 4);
        total++;
        if (q_a.size() != 2) begin
            bad++;
            $display("FAIL reset_access_count: got %0d accesses, want 2", q_a.size());
        end
        idx = find_acc(q_a, r0 + P);
        total++;
        if (idx < 0 || q_a[idx].wr !== 1'b0 || q_a[idx].addr !== 12'h000) begin
            bad++;
            $display("FAIL reset_first_read: no read of 0x000 at cycle %0d", r0 + P);
        end
        idx = find_acc(q_a, r0 + P + 2);
        total++;
        if (idx < 0 || q_a[idx].wr !== 1'b1 || q_a[idx].addr !== 12'h001 ||
            q_a[idx].data !== 64'h8000_0000_0000_0000) begin
            bad++;
            $display("FAIL reset_status_write: idx=%0d data=%h, want write @001 of 8000000000000000",
                     idx, (idx < 0) ? 64'h0 : q_a[idx].data);
        end
        total++;
        if (led_a !== 4'h0 || act_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_led: led=%h act=%b, want 0 0", led_a, act_a);
        end
    endtask

    task automatic test_blink(input logic [7:0] on, input logic [7:0] off, input int n);
        int t0, errs, idx, t, k, edges;
        logic [63:0] exp;
        cfg_a = {1'b1, 15'($urandom), 32'(n), off, on};
        do_reset();
        goto(r0 + 4 * P + 5);
        t0   = r0 + P + 2;
        errs = 0;
        for (t = t0; t <= r0 + 4 * P + 4; t++)
            if (hist_a[t % HIST] !== exp_led(t, t0, n, on, off)) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL blink_led n=%0d on=%h off=%h: %0d cycles wrong, want 0", n, on, off, errs);
        end
        for (int j = 0; j < 4; j++) begin
            t   = r0 + P + 2 + j * P;
            k   = (t - t0) / n;
            exp = {1'b1, 22'b0, ((k % 2) == 0), 4'b0, exp_led(t, t0, n, on, off), 32'(k)};
            idx = find_acc(q_a, t);
            total++;
            if (idx < 0 || q_a[idx].wr !== 1'b1 || q_a[idx].addr !== 12'h001 || q_a[idx].data !== exp) begin
                bad++;
                $display("FAIL blink_status%0d n=%0d: got %h, want %h", j, n,
                         (idx < 0) ? 64'h0 : q_a[idx].data, exp);
            end
        end
        edges = 0;
        for (t = t0 + 1; t <= r0 + 4 * P + 2; t++)
            if (hist_a[t % HIST] !== hist_a[(t - 1) % HIST]) edges++;
        idx = find_acc(q_a, r0 + 4 * P + 2);
        total++;
        if (idx < 0 || q_a[idx].data[31:0] !== 32'(edges)) begin
            bad++;
            $display("FAIL blink_edge_count: status toggles %0d, want %0d observed edges",
                     (idx < 0) ? -1 : int'(q_a[idx].data[31:0]), edges);
        end
        total++;
        if (q_a.size() != 8 || act_a !== 1'b1) begin
            bad++;
            $display("FAIL blink_accesses: got %0d accesses act=%b, want 8 and 1", q_a.size(), act_a);
        end
    endtask

    task automatic test_n_change();
        logic [7:0] on, off;
        int c3, errs, idx;
        on  = 8'($urandom);
        off = on ^ 8'($urandom_range(1, 15));
        cfg_a = {1'b1, 15'b0, 32'd100, off, on};
        do_reset();
        c3 = r0 + P + 1 + 2 * P;
        goto(r0 + 2 * P + 2);
        cfg_a = {1'b1, 15'b0, 32'd3, off, on};
        goto(c3 + 32);
        total++;
        if (hist_a[c3 % HIST] !== on[3:0]) begin
            bad++;
            $display("FAIL nchg_before: led %h at capture, want %h", hist_a[c3 % HIST], on[3:0]);
        end
        errs = 0;
        for (int t = c3 + 1; t <= c3 + 30; t++)
            if (hist_a[t % HIST] !== exp_led(t, c3 + 1, 3, off, on)) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL nchg_led: %0d cycles wrong after N 100->3, want 0", errs);
        end
        idx = find_acc(q_a, c3 + 1);
        total++;
        if (idx < 0 || q_a[idx].data !== {1'b1, 22'b0, 1'b0, 4'b0, off[3:0], 32'd1}) begin
            bad++;
            $display("FAIL nchg_status: got %h, want %h", (idx < 0) ? 64'h0 : q_a[idx].data,
                     {1'b1, 22'b0, 1'b0, 4'b0, off[3:0], 32'd1});
        end
    endtask

    task automatic test_steady();
        int errs, idx;
        cfg_a = {1'b1, 15'($urandom), 32'd0, 8'($urandom), 8'h0F};
        do_reset();
        goto(r0 + 11 * P + 3);
        errs = 0;
        for (int t = r0 + P + 2; t <= r0 + 11 * P + 3; t++)
            if (hist_a[t % HIST] !== 4'hF) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL steady_led: %0d cycles not 0xF, want 0", errs);
        end
        for (int j = 0; j < 10; j++) begin
            idx = find_acc(q_a, r0 + P + 2 + j * P);
            total++;
            if (idx < 0 || q_a[idx].data !== 64'h8000_010F_0000_0000) begin
                bad++;
                $display("FAIL steady_status%0d: got %h, want 8000010f00000000", j,
                         (idx < 0) ? 64'h0 : q_a[idx].data);
            end
        end
    endtask

    task automatic test_disable();
        logic [7:0] on, off;
        logic [63:0] exp;
        int t0, c3, idx;
        on  = 8'($urandom);
        off = on ^ 8'($urandom_range(1, 15));
        cfg_a = {1'b1, 15'b0, 32'd2, off, on};
        do_reset();
        t0 = r0 + P + 2;
        c3 = r0 + 3 * P + 1;
        goto(r0 + 2 * P + 2);
        cfg_a = {1'b0, 15'b0, 32'd2, off, on};
        goto(c3 + P + 3);
        exp = {1'b1, 22'b0, 1'b0, 8'h00, 32'((c3 - t0) / 2)};
        total++;
        if (hist_a[(c3 + 1) % HIST] !== 4'h0 || act_a !== 1'b0) begin
            bad++;
            $display("FAIL disable_led: led=%h act=%b, want 0 0", hist_a[(c3 + 1) % HIST], act_a);
        end
        for (int j = 0; j < 2; j++) begin
            idx = find_acc(q_a, c3 + 1 + j * P);
            total++;
            if (idx < 0 || q_a[idx].data !== exp) begin
                bad++;
                $display("FAIL disable_status%0d: got %h, want %h (held toggles)", j,
                         (idx < 0) ? 64'h0 : q_a[idx].data, exp);
            end
        end
    endtask

    task automatic test_latency2();
        logic [7:0] on, off;
        logic [63:0] exp;
        int n, t0, t, k, errs, idx;
        on  = 8'($urandom);
        off = on ^ 8'($urandom_range(1, 15));
        n   = int'($urandom_range(1, 6));
        cfg_b = {1'b1, 15'($urandom), 32'(n), off, on};
        do_reset();
        goto(r0 + 3 * P + 5);
        t0 = r0 + P + 3;
        for (int j = 0; j < 2; j++) begin
            idx = find_acc(q_b, r0 + P + j * P);
            total++;
            if (idx < 0 || q_b[idx].wr !== 1'b0 || q_b[idx].addr !== 12'h000) begin
                bad++;
                $display("FAIL lat2_read%0d: no read at cycle %0d", j, r0 + P + j * P);
            end
            t   = r0 + P + 3 + j * P;
            k   = (t - t0) / n;
            exp = {1'b1, 22'b0, ((k % 2) == 0), 4'b0, exp_led(t, t0, n, on, off), 32'(k)};
            idx = find_acc(q_b, t);
            total++;
            if (idx < 0 || q_b[idx].wr !== 1'b1 || q_b[idx].addr !== 12'h001 || q_b[idx].data !== exp) begin
                bad++;
                $display("FAIL lat2_status%0d: got %h, want %h", j, (idx < 0) ? 64'h0 : q_b[idx].data, exp);
            end
        end
        errs = 0;
        for (t = t0; t <= r0 + 3 * P + 4; t++)
            if (hist_b[t % HIST] !== exp_led(t, t0, n, on, off)) errs++;
        total++;
        if (errs != 0 || q_b.size() != 6) begin
            bad++;
            $display("FAIL lat2_led n=%0d: %0d cycles wrong, %0d accesses, want 0 and 6", n, errs, q_b.size());
        end
        total++;
        if (perr_a != 0 || perr_b != 0) begin
            bad++;
            $display("FAIL bus_protocol: violations a=%0d b=%0d, want 0 0", perr_a, perr_b);
        end
    endtask

    task automatic test_reset_mid_access();
        for (int v = 0; v < 2; v++) begin
            cfg_a = {1'b1, 15'b0, 32'd0, 8'h00, 8'h0F};
            do_reset();
            goto(r0 + ((v == 0) ? 2 * P : P + 2));
            total++;
            if (bus_a.ram_chipselect !== 1'b1 || bus_a.ram_write !== 1'(v) || led_a !== 4'hF) begin
                bad++;
                $display("FAIL midrst_setup%0d: cs=%b wr=%b led=%h, want 1 %0d f", v,
                         bus_a.ram_chipselect, bus_a.ram_write, led_a, v);
            end
            rst_n = 1'b0;
            #1;
            total++;
            if ({led_a, act_a, bus_a.ram_chipselect, bus_a.ram_clken, bus_a.ram_write} !== 8'h00 ||
                bus_a.ram_address !== 12'h000 || bus_a.ram_writedata !== 64'h0 || bus_a.ram_byteenable !== 8'h00) begin
                bad++;
                $display("FAIL midrst_outputs%0d: led=%h cs=%b addr=%h wd=%h, want all 0", v,
                         led_a, bus_a.ram_chipselect, bus_a.ram_address, bus_a.ram_writedata);
            end
            release_reset();
            goto(r0 + P + 3);
            total++;
            if (q_a.size() == 0 || q_a[0].cyc != r0 + P || q_a[0].wr !== 1'b0) begin
                bad++;
                $display("FAIL midrst_restart%0d: first access at %0d, want read at %0d", v,
                         (q_a.size() == 0) ? -1 : q_a[0].cyc - r0, P);
            end
        end
    endtask

    initial begin
        logic [7:0] on_r;
        test_reset();
        test_blink(8'h0A, 8'h05, 4);
        for (int i = 0; i < 3; i++) begin
            on_r = 8'($urandom);
            test_blink(on_r, on_r ^ 8'($urandom_range(1, 15)), int'($urandom_range(1, 6)));
        end
        test_n_change();
        test_steady();
        test_disable();
        test_latency2();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
